// File: rtl/i2c_mem_target_if.sv
// Bus-side signals of the I2C memory target: pad levels in, open-drain enable and write events out.
// master = bus/initiator side, slave = the target itself.
interface i2c_mem_target_if #(parameter int AW = 7);
  logic          scl_i;
  logic          sda_i;
  logic          sda_oe;
  logic          busy;
  logic          wr_evt;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  modport master (output scl_i, sda_i, input sda_oe, busy, wr_evt, wr_addr, wr_data);
  modport slave  (input scl_i, sda_i, output sda_oe, busy, wr_evt, wr_addr, wr_data);
endinterface

// File: rtl/i2c_mem_target.sv
// I2C target with 1-byte auto-incrementing pointer into a MEM_DEPTH x 8 register file; never stretches SCL.
// Bus edge to action takes 3 clk (2 sync + detect); sda_oe moves 1 clk after a detected SCL fall.
module i2c_mem_target #(
  parameter logic [6:0] DEV_ADDR  = 7'h50,
  parameter int         MEM_DEPTH = 128
) (
  input  logic clk,
  input  logic rst,
  i2c_mem_target_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  // [0],[1] synchronizer, [2] history for edge detection
  logic [2:0] scl_s, sda_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s <= 3'b111;
      sda_s <= 3'b111;
    end else begin
      scl_s <= {scl_s[1:0], bus.scl_i};
      sda_s <= {sda_s[1:0], bus.sda_i};
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det, sda_now;
  assign scl_rise  =  scl_s[1] & ~scl_s[2];
  assign scl_fall  = ~scl_s[1] &  scl_s[2];
  assign start_det =  scl_s[1] &  scl_s[2] &  sda_s[2] & ~sda_s[1];
  assign stop_det  =  scl_s[1] &  scl_s[2] & ~sda_s[2] &  sda_s[1];
  assign sda_now   =  sda_s[1];

  state_t        state;
  logic [3:0]    bitcnt;
  logic [7:0]    shreg;
  logic          rw;
  logic [AW-1:0] ptr;
  logic          sda_oe_q, busy_q, wr_evt_q;
  logic [AW-1:0] wr_addr_q;
  logic [7:0]    wr_data_q;
  logic [7:0]    mem [MEM_DEPTH];

  logic addr_match;
  assign addr_match = (shreg[7:1] == DEV_ADDR) && (shreg[7:1] != 7'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      rw        <= 1'b0;
      ptr       <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_evt_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_evt_q <= 1'b0;
      if (start_det) begin
        state    <= ADDR;
        bitcnt   <= '0;
        sda_oe_q <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        if (scl_rise && (state == ADDR || state == PTR || state == WDATA) && bitcnt != 4'd8) begin
          shreg  <= {shreg[6:0], sda_now};
          bitcnt <= bitcnt + 4'd1;
        end
        case (state)
          ADDR:
            if (scl_fall && bitcnt == 4'd8) begin
              bitcnt <= '0;
              if (addr_match) begin
                rw       <= shreg[0];
                sda_oe_q <= 1'b1;
                busy_q   <= 1'b1;
                state    <= ADDR_ACK;
              end else begin
                state <= WAIT_STOP;
              end
            end
          ADDR_ACK:
            if (scl_fall) begin
              if (!rw) begin
                sda_oe_q <= 1'b0;
                bitcnt   <= '0;
                state    <= PTR;
              end else begin
                sda_oe_q <= ~mem[ptr][7];
                shreg    <= {mem[ptr][6:0], 1'b0};
                bitcnt   <= 4'd1;
                state    <= RDATA;
              end
            end
          PTR:
            if (scl_fall && bitcnt == 4'd8) begin
              ptr      <= shreg[AW-1:0];
              sda_oe_q <= 1'b1;
              state    <= PTR_ACK;
            end
          PTR_ACK, WDATA_ACK:
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              bitcnt   <= '0;
              state    <= WDATA;
            end
          WDATA:
            if (scl_fall && bitcnt == 4'd8) begin
              mem[ptr]  <= shreg;
              wr_evt_q  <= 1'b1;
              wr_addr_q <= ptr;
              wr_data_q <= shreg;
              ptr       <= ptr + 1'b1;
              sda_oe_q  <= 1'b1;
              state     <= WDATA_ACK;
            end
          RDATA:
            if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                sda_oe_q <= 1'b0;
                bitcnt   <= '0;
                state    <= RDATA_ACK;
              end else begin
                sda_oe_q <= ~shreg[7];
                shreg    <= {shreg[6:0], 1'b0};
                bitcnt   <= bitcnt + 4'd1;
              end
            end
          RDATA_ACK:
            // bitcnt==1 marks "initiator ACKed, next byte starts at the coming fall"
            if (scl_rise) begin
              if (sda_now) begin
                state <= WAIT_STOP;
              end else begin
                ptr    <= ptr + 1'b1;
                bitcnt <= 4'd1;
              end
            end else if (scl_fall && bitcnt == 4'd1) begin
              sda_oe_q <= ~mem[ptr][7];
              shreg    <= {mem[ptr][6:0], 1'b0};
              state    <= RDATA;
            end
          IDLE, WAIT_STOP: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.sda_oe  = sda_oe_q;
  assign bus.busy    = busy_q;
  assign bus.wr_evt  = wr_evt_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
endmodule
